// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: bit-serial magnitude comparator, MSB first.
// Operands are captured on an accepted start. One bit pair is examined per
// enabled clock, and the registered gt/eq/lt result is loaded when the scan
// finishes.
// Optional build macro CMP_EARLY_EXIT_EN: finish the scan on the first
// differing bit instead of always scanning all WIDTH bits.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ena,
    input  logic             i_start,
    input  logic             i_signed_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_gt,
    output logic             o_eq,
    output logic             o_lt
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_signed;
    logic [IW-1:0]    r_idx;
    logic             r_found;   // a differing bit has already been seen
    logic             r_dgt;     // direction of that first difference (1 = A>B)
    logic             r_gt, r_eq, r_lt;

    logic w_abit, w_bbit, w_differ, w_msb, w_bit_gt, w_last;
    logic w_fin_found, w_fin_gt;

    // Current bit pair and its verdict; the sign bit compares inverted in signed mode
    always_comb begin
        w_abit      = r_a[r_idx];
        w_bbit      = r_b[r_idx];
        w_differ    = w_abit ^ w_bbit;
        w_msb       = (r_idx == IW'(WIDTH - 1));
        w_bit_gt    = (r_signed && w_msb) ? w_bbit : w_abit;
        w_fin_found = r_found | w_differ;
        w_fin_gt    = r_found ? r_dgt : w_bit_gt;
`ifdef CMP_EARLY_EXIT_EN
        w_last      = (r_idx == '0) || w_differ;
`else
        w_last      = (r_idx == '0);
`endif
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; nothing moves without the clock enable
    always_comb begin
        w_state_nxt = r_state;
        if (i_ena) begin
            case (r_state)
                IDLE:    if (i_start) w_state_nxt = COMPARE;
                COMPARE: if (w_last)  w_state_nxt = DONE;
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Operand capture, serial scan and result load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_found  <= 1'b0;
            r_dgt    <= 1'b0;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
        end else if (i_ena) begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_signed <= i_signed_mode;
                        r_idx    <= IW'(WIDTH - 1);
                        r_found  <= 1'b0;
                        r_dgt    <= 1'b0;
                    end
                end
                COMPARE: begin
                    // Only the first difference is remembered
                    if (!r_found && w_differ) begin
                        r_found <= 1'b1;
                        r_dgt   <= w_bit_gt;
                    end
                    if (w_last) begin
                        r_gt <= w_fin_found &  w_fin_gt;
                        r_lt <= w_fin_found & ~w_fin_gt;
                        r_eq <= ~w_fin_found;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state == COMPARE);
    assign o_done = (r_state == DONE);
    assign o_gt   = r_gt;
    assign o_eq   = r_eq;
    assign o_lt   = r_lt;

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  clock-enable; 0 freezes all state.
REQ-005 start  input  1  request a comparison; sampled only in IDLE.
REQ-006 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with operands.
REQ-007 a  input  WIDTH  operand A; captured on accepted start.
REQ-008 b  input  WIDTH  operand B; captured on accepted start.
REQ-009 busy  output  1  high while in COMPARE.
REQ-010 done  output  1  single-cycle pulse marking a valid result.
REQ-011 gt  output  1  registered A>B result.
REQ-012 eq  output  1  registered A==B result.
REQ-013 lt  output  1  registered A<B result.

Function
REQ-014 The FSM SHALL have the states IDLE, COMPARE and DONE; all transitions require ena=1.
REQ-015 In IDLE with start=1, the edge SHALL capture a, b and signed_mode, set bit index to WIDTH-1 and enter COMPARE.
REQ-016 Each COMPARE edge SHALL examine one bit pair, MSB first, and decrement the index.
REQ-017 At index WIDTH-1 with signed_mode=1, sense SHALL invert: a_bit=1,b_bit=0 gives A<B, and a_bit=0,b_bit=1 gives A>B.
REQ-018 The first differing bit SHALL fix the result; later bits SHALL NOT change it.
REQ-019 No difference over all bits SHALL give eq.
REQ-020 The edge processing the final examined bit SHALL load gt/eq/lt and enter DONE; done=1 for exactly the DONE cycle; the next enabled edge SHALL return to IDLE.
REQ-021 With start accepted at edge k, done SHALL rise at edge k+WIDTH (full-scan latency).
REQ-022 gt/eq/lt SHALL hold until the next result load; after the first result exactly one SHALL be high.
REQ-023 start SHALL be ignored in COMPARE and DONE; operand changes there SHALL have no effect.
REQ-024 ena=0 in any state SHALL hold state, index, busy, done and results; latency extends by the number of stalled cycles.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, gt=0, eq=0, lt=0, and clear the operand registers and index.
REQ-026 Reset during COMPARE SHALL abort the comparison; no done pulse SHALL follow rst_n release.
REQ-027 After rst_n release, operation SHALL resume from IDLE on the first enabled edge.

Configuration
REQ-028 Macro CMP_EARLY_EXIT_EN, when defined, SHALL end COMPARE on the edge that finds the first differing bit; a difference at index i gives done at edge k+(WIDTH-i).
REQ-029 Without CMP_EARLY_EXIT_EN, latency SHALL be WIDTH edges for every operand pair (REQ-021).
REQ-030 Equal operands SHALL take WIDTH edges in both configurations.

Verification (WIDTH=8, start accepted at edge k)
REQ-031 a=0xA5, b=0x5A, unsigned -> gt=1, eq=0, lt=0; done at k+1 with the macro, at k+8 without.
REQ-032 a=b=0x3C -> eq=1; done at k+8 in both configurations.
REQ-033 a=0xFF, b=0x01: signed_mode=1 -> lt=1, signed_mode=0 -> gt=1.
REQ-034 a=0x12, b=0x13, no macro; ena=0 for 3 cycles mid-COMPARE; start pulse with a=0x00 during busy -> lt=1, done at k+11, second start ignored.
REQ-035 a=0x40, b=0x41 with the macro -> lt=1, done at k+8 (difference at index 0).
REQ-036 rst_n low at edge k+4 -> busy, done and gt/eq/lt read 0; no done within 20 cycles after release without a new start.
